// File: rtl/haze_pkg.sv
// Shared state encoding, pass constants and default image geometry for the
// two-pass haze-removal frame sequencer.
package haze_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALE_PASS,
    ALE_WAIT,
    TE_PASS,
    DRAIN,
    DONE
  } seq_state_t;

  localparam logic PASS_ALE = 1'b0;
  localparam logic PASS_TE  = 1'b1;

  localparam int DEF_IMG_WIDTH  = 512;
  localparam int DEF_IMG_HEIGHT = 512;
  localparam int DEF_CNT_W      = 20;

endpackage

// File: rtl/haze_frame_counter.sv
// Beat counter with column/row tracking; clear has priority over increment.
// Row wraps back to 0 after the last row so it never leaves its range.
module haze_frame_counter #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int CNT_W      = 20
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          clr,
  input  logic                          inc,
  output logic [CNT_W-1:0]              cnt,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [$clog2(IMG_HEIGHT)-1:0] row
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;

  always_comb begin
    cnt_next = cnt_reg;
    col_next = col_reg;
    row_next = row_reg;
    if (clr) begin
      cnt_next = '0;
      col_next = '0;
      row_next = '0;
    end else if (inc) begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_next = col_reg + COL_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_reg <= '0;
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  assign cnt = cnt_reg;
  assign col = col_reg;
  assign row = row_reg;

endmodule

// File: rtl/haze_pass_sequencer.sv
// Frame-level two-pass controller (ALE pass, then TE/SRSC pass) for the haze datapath.
// Optional TLAST consistency checking is enabled by defining HAZE_SEQ_TLAST_CHECK_EN.
module haze_pass_sequencer
  import haze_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          enable,
  input  logic                          s_valid,
  input  logic                          s_tlast,
  input  logic                          dp_ready,
  input  logic                          ale_done,
  input  logic                          m_valid,
  input  logic                          m_ready,
  output logic                          s_accept,
  output logic                          pass_sel,
  output logic                          ale_en,
  output logic                          te_en,
  output logic                          m_en,
  output logic                          m_tlast,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic                          frame_done,
  output logic                          err_tlast
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  seq_state_t state_reg, state_next;

  logic in_beat, out_beat, in_last, out_last;
  logic ale_go;

  // Index 0 counts accepted input beats, index 1 counts output beats.
  logic [1:0]       cnt_clr, cnt_inc;
  logic [CNT_W-1:0] cnt_arr [2];
  logic [COL_W-1:0] col_arr [2];
  logic [ROW_W-1:0] row_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      haze_frame_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .CNT_W     (CNT_W)
      ) u_cnt (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .clr    (cnt_clr[gi]),
        .inc    (cnt_inc[gi]),
        .cnt    (cnt_arr[gi]),
        .col    (col_arr[gi]),
        .row    (row_arr[gi])
      );
    end
  endgenerate

  // Moore decode: everything below depends only on registered state/counters.
  assign s_accept   = (state_reg == ALE_PASS) || (state_reg == TE_PASS);
  assign ale_en     = (state_reg == ALE_PASS);
  assign te_en      = (state_reg == TE_PASS) || (state_reg == DRAIN);
  assign m_en       = te_en;
  assign pass_sel   = (state_reg inside {TE_PASS, DRAIN, DONE}) ? PASS_TE : PASS_ALE;
  assign frame_done = (state_reg == DONE);
  assign m_tlast    = m_en && out_last;
  assign col        = col_arr[0];
  assign row        = row_arr[0];

  assign in_beat  = s_valid && s_accept && dp_ready;
  assign out_beat = m_valid && m_en && m_ready;
  assign in_last  = (cnt_arr[0] == LAST_BEAT);
  assign out_last = (cnt_arr[1] == LAST_BEAT);
  assign ale_go   = (state_reg == ALE_WAIT) && ale_done;

  assign cnt_inc[0] = in_beat;
  assign cnt_inc[1] = out_beat;
  assign cnt_clr[0] = ((state_reg == IDLE) && enable) || ale_go;
  assign cnt_clr[1] = ale_go;

  // Only the input counter's position is meaningful.
  logic unused_out_pos;
  assign unused_out_pos = ^{col_arr[1], row_arr[1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (enable)              state_next = ALE_PASS;
      ALE_PASS: if (in_beat && in_last)  state_next = ALE_WAIT;
      ALE_WAIT: if (ale_done)            state_next = TE_PASS;
      TE_PASS:  if (in_beat && in_last)  state_next = DRAIN;
      DRAIN:    if (out_beat && out_last) state_next = DONE;
      DONE:                              state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

`ifdef HAZE_SEQ_TLAST_CHECK_EN
  logic err_reg;

  // Sticky: any beat whose TLAST disagrees with the beat count latches the flag.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                           err_reg <= 1'b0;
    else if (in_beat && (s_tlast != in_last)) err_reg <= 1'b1;
  end

  assign err_tlast = err_reg;
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign err_tlast    = 1'b0;
`endif

endmodule

// File: doc/haze_pass_sequencer.md
# haze_pass_sequencer

Frame-level controller for the two-pass haze-removal datapath. Pass 1 streams the image through atmospheric light estimation (ALE). Pass 2 streams the same image through transmission estimation (TE) and scene recovery (SRSC). The block gates the AXI4-Stream input, selects the active pass, supplies pixel coordinates, generates output TLAST and signals frame completion. It sits beside the datapath inside the top-level stream wrapper; `S_AXIS_TREADY = s_accept & dp_ready`.

## Interface
- `IMG_WIDTH`, 512, pixels per row
- `IMG_HEIGHT`, 512, rows per frame
- `CNT_W`, 20, beat-counter width; must satisfy 2^CNT_W > IMG_WIDTH*IMG_HEIGHT
- `ACLK`  in  1  single clock, rising edge
- `ARESETn`  in  1  reset, asynchronous assert, active-low
- `enable`  in  1  permits a new frame to start; sampled only in IDLE
- `s_valid`  in  1  S_AXIS_TVALID from upstream
- `s_tlast`  in  1  S_AXIS_TLAST from upstream
- `dp_ready`  in  1  datapath input ready
- `ale_done`  in  1  one-cycle pulse from ALE once atmospheric light is latched
- `m_valid`  in  1  datapath output valid (M_AXIS_TVALID)
- `m_ready`  in  1  downstream M_AXIS_TREADY
- `s_accept`  out  1  input acceptance gate
- `pass_sel`  out  1  0 = ALE pass, 1 = TE/SRSC pass
- `ale_en`  out  1  ALE accumulate enable
- `te_en`  out  1  TE/SRSC enable
- `m_en`  out  1  output stream enable; the wrapper ANDs it into M_AXIS_TVALID
- `m_tlast`  out  1  M_AXIS_TLAST
- `col`  out  clog2(IMG_WIDTH)  column of the current input pixel
- `row`  out  clog2(IMG_HEIGHT)  row of the current input pixel
- `frame_done`  out  1  one-cycle pulse at frame end
- `err_tlast`  out  1  sticky TLAST-mismatch flag

## Operation
- Definitions:
  - N = IMG_WIDTH*IMG_HEIGHT.
  - in_beat = s_valid & s_accept & dp_ready.
  - out_beat = m_valid & m_en & m_ready.
- FSM states and transitions:
  - IDLE → ALE_PASS when enable=1.
  - ALE_PASS → ALE_WAIT on the in_beat with in_cnt==N-1.
  - ALE_WAIT → TE_PASS on ale_done.
  - TE_PASS → DRAIN on the in_beat with in_cnt==N-1.
  - DRAIN → DONE on the out_beat with out_cnt==N-1.
  - DONE → IDLE unconditionally.
- Output decode:
  - s_accept = ALE_PASS | TE_PASS.
  - ale_en = ALE_PASS.
  - te_en = m_en = TE_PASS | DRAIN.
  - pass_sel = TE_PASS | DRAIN | DONE.
  - frame_done = DONE.
- Input counter `in_cnt`:
  - Increments on in_beat.
  - Clears on entry to ALE_PASS and to TE_PASS.
  - col/row track in_cnt: col wraps at IMG_WIDTH-1, and row increments on that wrap.
- Output counter `out_cnt`:
  - Increments on out_beat in TE_PASS or DRAIN; out_beats are counted in TE_PASS, since output may start before input ends.
  - Clears on entry to TE_PASS.
  - m_tlast = m_en & (out_cnt==N-1).
- Pulses and beats outside the expected states:
  - ale_done outside ALE_WAIT is ignored.
  - m_valid during ALE_PASS is masked by m_en=0 and not counted.
- enable deasserted mid-frame has no effect; the frame completes.
- DRAIN reached with out_cnt already N is impossible by construction. The datapath emits exactly N outputs per pass 2.

## Timing
- Moore outputs only: every output is a decode of state, out_cnt or the error register, with no input-to-output path.
- The final in_beat of a pass occurs in cycle t; s_accept is 0 from cycle t+1.
- ale_done in cycle t gives s_accept=1 in cycle t+1.
- frame_done asserts for exactly one cycle, in the cycle after the final out_beat.
- IDLE → ALE_PASS takes 1 cycle after enable is sampled high.
- Back-to-back frames: DONE → IDLE → ALE_PASS gives a minimum 2-cycle gap.
- Reset values:
  - state IDLE; counters 0.
  - All outputs 0, except col = row = 0.
  - err_tlast 0.
- Reset asserted mid-frame immediately returns the block to IDLE. Any partial beat is discarded.

## Configuration
- `HAZE_SEQ_TLAST_CHECK_EN` defined: on every in_beat, err_tlast sets if s_tlast != (in_cnt==N-1). The flag is sticky until reset. The pass still advances on count, never on s_tlast.
- Macro undefined: s_tlast is ignored and err_tlast is tied 0.

## Structure
- Package `haze_pkg`:
  - state enum `seq_state_t` (IDLE, ALE_PASS, ALE_WAIT, TE_PASS, DRAIN, DONE).
  - `PASS_ALE`/`PASS_TE` constants.
  - default image dimensions.
- Sub-module `haze_frame_counter`: beat counter with col/row wrap, enable and synchronous clear. Instantiated once for input and once for output; output col/row are left unused.

## Test plan
All scenarios use IMG_WIDTH=4 and IMG_HEIGHT=2 (N=8).
- Nominal frame:
  - Stimulus: enable=1, continuous s_valid/dp_ready, ale_done 3 cycles after pass 1, m_valid/m_ready tied high in pass 2.
  - Response: exactly 8 beats accepted per pass; m_tlast on the 8th output beat; one frame_done pulse; state returns to IDLE.
- Backpressure:
  - Stimulus: dp_ready and m_ready toggle at random.
  - Response: counts advance only on qualified beats; col/row follow the sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1); m_tlast appears only on out_cnt=7.
- ALE_WAIT hold:
  - Stimulus: delay ale_done 50 cycles; pulse ale_done during ALE_PASS.
  - Response: s_accept stays 0 throughout the wait; the early pulse is ignored.
- Mid-frame reset:
  - Stimulus: ARESETn low at in_cnt=5 of pass 2.
  - Response: all outputs return to reset values asynchronously; a new frame starts cleanly.
- TLAST check (macro defined):
  - Stimulus: s_tlast asserted on beat 6 of pass 1.
  - Response: err_tlast=1 and sticky; the pass still ends after 8 beats.
- TLAST check (macro undefined):
  - Stimulus: same as above.
  - Response: err_tlast remains 0.
